// File: rtl/odd_div_pkg.sv
// Shared definitions for the odd clock divider and its monitor.
package odd_div_pkg;

    // Default counter width, shared with the divider itself.
    localparam int unsigned ODD_DIV_CNT_W = 8;

    // Monitor FSM encoding.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_EDGE = 2'd1,
        ST_MEAS      = 2'd2
    } state_e;

endpackage : odd_div_pkg

// File: rtl/odd_div_monitor_edge_sync.sv
// Two-flop synchronizer for the divided clock plus rising-edge detect.
module edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic level_o,
    output logic rise_c_o
);

    logic s1_q;
    logic s2_q;
    logic prev_q;

    // Synchronizer chain and one-cycle delayed copy for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            s1_q   <= d_i;
            s2_q   <= s1_q;
            prev_q <= s2_q;
        end
    end

    assign level_o  = s2_q;
    assign rise_c_o = s2_q & ~prev_q;

endmodule : edge_sync

// File: rtl/odd_div_monitor.sv
// Measures period and high time of a divided clock on the reference clock
// and reports lock against the expected ratio, plus a sticky error.
module odd_div_monitor
    import odd_div_pkg::*;
#(
    parameter int unsigned CNT_W    = ODD_DIV_CNT_W,
    parameter int unsigned EXP_DIV  = 5,
    parameter int unsigned LOCK_CNT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             div_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             locked,
    output logic             err
);

    localparam int unsigned      MC_W     = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] EXP_VAL  = CNT_W'(EXP_DIV);
    localparam logic [MC_W-1:0]  LOCK_TGT = MC_W'(LOCK_CNT);
    localparam logic [MC_W-1:0]  MC_ONE   = MC_W'(1);

    state_e state_q;
    state_e state_d;

    logic             level;
    logic             rise_c;
    logic             timeout_c;
    logic             match_c;

    logic [CNT_W-1:0] per_cnt_q;
    logic [CNT_W-1:0] per_cnt_d;
    logic [CNT_W-1:0] hi_cnt_q;
    logic [CNT_W-1:0] hi_cnt_d;
    logic [MC_W-1:0]  match_q;
    logic [MC_W-1:0]  match_d;
    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] period_d;
    logic [CNT_W-1:0] high_q;
    logic [CNT_W-1:0] high_d;
    logic             mv_q;
    logic             mv_d;
    logic             locked_q;
    logic             locked_d;
    logic             err_q;
    logic             err_d;

    edge_sync u_edge_sync (
        .clk      (clk),
        .rst      (rst),
        .d_i      (div_in),
        .level_o  (level),
        .rise_c_o (rise_c)
    );

    // A rise in the saturating cycle still counts as a normal capture.
    assign timeout_c = (state_q == ST_MEAS) && !rise_c && (per_cnt_q == CNT_MAX);
    assign match_c   = (per_cnt_q == EXP_VAL);

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state; a low enable overrides everything, including a rise.
    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:      state_d = ST_WAIT_EDGE;
                ST_WAIT_EDGE: if (rise_c) state_d = ST_MEAS;
                ST_MEAS:      if (timeout_c) state_d = ST_WAIT_EDGE;
                default:      state_d = ST_IDLE;
            endcase
        end
    end

    // FSM outputs: counters, captures, lock tracking and sticky error.
    always_comb begin
        per_cnt_d = per_cnt_q;
        hi_cnt_d  = hi_cnt_q;
        match_d   = match_q;
        period_d  = period_q;
        high_d    = high_q;
        mv_d      = 1'b0;
        locked_d  = locked_q;
        err_d     = err_q;

        if (!en) begin
            per_cnt_d = '0;
            hi_cnt_d  = '0;
            match_d   = '0;
            period_d  = '0;
            high_d    = '0;
            locked_d  = 1'b0;
            err_d     = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    per_cnt_d = '0;
                    hi_cnt_d  = '0;
                    match_d   = '0;
                    locked_d  = 1'b0;
                    err_d     = 1'b0;
                end
                ST_WAIT_EDGE: begin
                    if (rise_c) begin
                        per_cnt_d = CNT_ONE;
                        hi_cnt_d  = CNT_ONE;
                    end
                end
                ST_MEAS: begin
                    if (rise_c) begin
                        period_d  = per_cnt_q;
                        high_d    = hi_cnt_q;
                        mv_d      = 1'b1;
                        per_cnt_d = CNT_ONE;
                        hi_cnt_d  = CNT_ONE;
                        if (match_c) begin
                            match_d  = (match_q >= LOCK_TGT) ? LOCK_TGT : match_q + MC_ONE;
                            locked_d = (32'(match_q) + 32'd1) >= LOCK_CNT;
                        end else begin
                            match_d  = '0;
                            locked_d = 1'b0;
                            err_d    = 1'b1;
                        end
                    end else if (timeout_c) begin
                        match_d  = '0;
                        locked_d = 1'b0;
                        err_d    = 1'b1;
                    end else begin
                        // per_cnt_q < CNT_MAX here, so the increment cannot wrap.
                        per_cnt_d = per_cnt_q + CNT_ONE;
                        if (level && (hi_cnt_q != CNT_MAX)) begin
                            hi_cnt_d = hi_cnt_q + CNT_ONE;
                        end
                    end
                end
                default: begin
                    per_cnt_d = '0;
                    hi_cnt_d  = '0;
                end
            endcase
        end
    end

    // Datapath and status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            per_cnt_q <= '0;
            hi_cnt_q  <= '0;
            match_q   <= '0;
            period_q  <= '0;
            high_q    <= '0;
            mv_q      <= 1'b0;
            locked_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            per_cnt_q <= per_cnt_d;
            hi_cnt_q  <= hi_cnt_d;
            match_q   <= match_d;
            period_q  <= period_d;
            high_q    <= high_d;
            mv_q      <= mv_d;
            locked_q  <= locked_d;
            err_q     <= err_d;
        end
    end

    assign period     = period_q;
    assign high_time  = high_q;
    assign meas_valid = mv_q;
    assign locked     = locked_q;
    assign err        = err_q;

endmodule : odd_div_monitor

// File: tb/tb_odd_div_monitor.sv
// Bench for odd_div_monitor: edge-indexed reference model plus directed phases.
module tb_odd_div_monitor;
    import odd_div_pkg::*;

    localparam int unsigned CNT_W    = 4;
    localparam int unsigned EXP_DIV  = 5;
    localparam int unsigned LOCK_CNT = 4;
    localparam int          MAXC     = 15;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             div_in;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             meas_valid;
    logic             locked;
    logic             err;

    int n_checks = 0;
    int n_fail   = 0;

    odd_div_monitor #(
        .CNT_W    (CNT_W),
        .EXP_DIV  (EXP_DIV),
        .LOCK_CNT (LOCK_CNT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .div_in     (div_in),
        .period     (period),
        .high_time  (high_time),
        .meas_valid (meas_valid),
        .locked     (locked),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: works on edge indices. h[k] is div_in seen at edge k;
    // a rise used at edge n means h[n-2]=1 and h[n-3]=0. Period is the
    // distance between consecutive rise edges.
    bit h [0:4095];
    int n      = 0;
    int hbase  = 1;
    int m_st   = 0;     // 0 idle, 1 waiting for first rise, 2 measuring
    int t0     = 0;
    int m_match = 0;
    int m_period = 0, m_high = 0, m_mv = 0, m_locked = 0, m_err = 0;
    bit m_r;
    int m_p;

    function automatic bit hv(input int k);
        return (k >= hbase && k >= 0) ? h[k] : 1'b0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_st = 0; m_match = 0;
            m_period = 0; m_high = 0; m_mv = 0; m_locked = 0; m_err = 0;
            hbase = n + 1;
        end else begin
            n++;
            h[n] = div_in;
            m_r  = hv(n - 2) && !hv(n - 3);
            m_mv = 0;
            if (!en) begin
                m_st = 0; m_match = 0;
                m_period = 0; m_high = 0; m_locked = 0; m_err = 0;
            end else if (m_st == 0) begin
                m_st = 1;
            end else if (m_st == 1) begin
                if (m_r) begin t0 = n; m_st = 2; end
            end else begin
                if (m_r) begin
                    m_p = n - t0;
                    m_period = m_p;
                    m_high = 0;
                    for (int k = t0 - 2; k <= n - 3; k++) m_high += int'(hv(k));
                    m_mv = 1;
                    if (m_p == int'(EXP_DIV)) begin
                        m_locked = (m_match + 1 >= int'(LOCK_CNT)) ? 1 : 0;
                        m_match  = (m_match + 1 > int'(LOCK_CNT)) ? int'(LOCK_CNT) : m_match + 1;
                    end else begin
                        m_match = 0; m_locked = 0; m_err = 1;
                    end
                    t0 = n;
                end else if (n - t0 >= MAXC) begin
                    m_err = 1; m_locked = 0; m_match = 0; m_st = 1;
                end
            end
        end
    end

    typedef struct {
        int  per;
        int  hi;
        bit  lk;
        bit  er;
        time t;
    } cap_t;
    cap_t caps [$];
    cap_t c;

    // Every-cycle comparison against the model, and capture log.
    always @(negedge clk) begin
        chk("period",     32'(period),     32'(m_period));
        chk("high_time",  32'(high_time),  32'(m_high));
        chk("meas_valid", 32'(meas_valid), 32'(m_mv));
        chk("locked",     32'(locked),     32'(m_locked));
        chk("err",        32'(err),        32'(m_err));
        if (meas_valid === 1'b1) begin
            c.per = int'(period); c.hi = int'(high_time);
            c.lk = locked; c.er = err; c.t = $time;
            caps.push_back(c);
        end
    end

    task automatic cyc(input logic d, input logic e);
        @(posedge clk);
        #1;
        div_in = d;
        en     = e;
    endtask

    task automatic pat(input int hi, input int lo, input int reps);
        for (int r = 0; r < reps; r++) begin
            for (int i = 0; i < hi; i++) cyc(1'b1, 1'b1);
            for (int i = 0; i < lo; i++) cyc(1'b0, 1'b1);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_period"}, 32'(period),     32'd0);
        chk({tag, "_high"},   32'(high_time),  32'd0);
        chk({tag, "_mv"},     32'(meas_valid), 32'd0);
        chk({tag, "_locked"}, 32'(locked),     32'd0);
        chk({tag, "_err"},    32'(err),        32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; en = 1'b0; div_in = 1'b0;
        #22;
        chk_zero("reset");
        #10 rst = 1'b0;

        // Nominal 3/2 pattern: lock on the 4th capture.
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1);
        pat(3, 2, 6);
        chk("a_ncap", 32'(caps.size()), 32'd5);
        if (caps.size() == 5) begin
            chk("a_per0",    32'(caps[0].per), 32'd5);
            chk("a_hi0",     32'(caps[0].hi),  32'd3);
            chk("a_spacing", 32'(caps[1].t - caps[0].t), 32'd50);
            chk("a_lk2",     32'(caps[2].lk),  32'd0);
            chk("a_lk3",     32'(caps[3].lk),  32'd1);
            chk("a_err4",    32'(caps[4].er),  32'd0);
        end

        // One 7-cycle period, four good periods, then div_in stuck low.
        caps.delete();
        pat(4, 3, 1);
        pat(3, 2, 4);
        pat(3, 25, 1);
        chk("b_ncap", 32'(caps.size()), 32'd6);
        if (caps.size() == 6) begin
            chk("b_per1", 32'(caps[1].per), 32'd7);
            chk("b_lk1",  32'(caps[1].lk),  32'd0);
            chk("b_err1", 32'(caps[1].er),  32'd1);
            chk("b_lk4",  32'(caps[4].lk),  32'd0);
            chk("b_lk5",  32'(caps[5].lk),  32'd1);
            chk("b_err5", 32'(caps[5].er),  32'd1);
        end
        chk("to_locked", 32'(locked), 32'd0);
        chk("to_err",    32'(err),    32'd1);
        chk("to_period", 32'(period), 32'd5);
        chk("to_state",  32'(dut.state_q), 32'(ST_WAIT_EDGE));

        // Recovery after timeout needs a fresh first rise.
        caps.delete();
        pat(3, 2, 5);
        chk("c_ncap", 32'(caps.size()), 32'd4);
        if (caps.size() == 4) begin
            chk("c_lk2", 32'(caps[2].lk), 32'd0);
            chk("c_lk3", 32'(caps[3].lk), 32'd1);
        end

        // Drop enable for one cycle while locked.
        caps.delete();
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b1);
        @(negedge clk);
        chk("en_locked", 32'(locked), 32'd0);
        chk("en_err",    32'(err),    32'd0);
        chk("en_period", 32'(period), 32'd0);
        cyc(1'b1, 1'b1);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b1);
        pat(3, 2, 4);
        chk("d_ncap", 32'(caps.size()), 32'd4);
        if (caps.size() == 4) begin
            chk("d_lk2",  32'(caps[2].lk), 32'd0);
            chk("d_lk3",  32'(caps[3].lk), 32'd1);
            chk("d_err0", 32'(caps[0].er), 32'd0);
        end

        // Asynchronous reset mid-period.
        cyc(1'b1, 1'b1);
        @(posedge clk);
        #4 rst = 1'b1;
        #1;
        chk_zero("arst");
        div_in = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        caps.delete();
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b1);
        pat(3, 2, 6);
        chk("e_ncap", 32'(caps.size()), 32'd5);
        if (caps.size() == 5) begin
            chk("e_per0", 32'(caps[0].per), 32'd5);
            chk("e_lk3",  32'(caps[3].lk),  32'd1);
            chk("e_err4", 32'(caps[4].er),  32'd0);
        end

        // Rise in the same cycle enable falls: no capture, back to idle.
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk("f_mv",     32'(meas_valid), 32'd0);
        chk("f_locked", 32'(locked),     32'd0);
        chk("f_period", 32'(period),     32'd0);
        chk("f_ncap",   32'(caps.size()), 32'd5);
        chk("f_state",  32'(dut.state_q), 32'(ST_IDLE));

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_odd_div_monitor

// File: doc/odd_div_monitor.md
# odd_div_monitor

Clock-domain-local checker for the output of the odd clock divider. It samples a divided clock on the reference clock and measures its period and high time in reference-clock cycles. It asserts `locked` once the period has matched the expected division ratio for a programmable number of consecutive periods. It sits next to the divider on the same `clk` and drives status bits for bring-up and self-test.

## Interface
Parameters:
- `CNT_W`, 8: width of the period, high-time and internal counters.
- `EXP_DIV`, 5: expected period of `div_in` in `clk` cycles; an odd value ≥ 3.
- `LOCK_CNT`, 4: number of consecutive matching periods required to assert `locked`; ≥ 1.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: reference clock, the same clock that feeds the divider.
- `rst` in 1: asynchronous, active-high reset.
- `en` in 1: monitor enable; low forces IDLE.
- `div_in` in 1: divided clock under test; treated as asynchronous.
- `period` out CNT_W: last measured period in `clk` cycles.
- `high_time` out CNT_W: number of cycles in the last period where the sampled `div_in` was 1.
- `meas_valid` out 1: one-cycle pulse when `period`/`high_time` update.
- `locked` out 1: `LOCK_CNT` consecutive periods equal to `EXP_DIV`.
- `err` out 1: sticky error (mismatch or timeout); clears only when `en` goes low or on `rst`.

## Operation
- Input path:
  - 2-flop synchronizer `s1 → s2`, plus a `prev` flop.
  - `rise = s2 & ~prev`.
- Counting rules:
  - `per_cnt`: set to 1 on `rise`, otherwise incremented.
  - `hi_cnt`: set to 1 on `rise`, otherwise incremented by `s2`.
  - Both saturate at 2^CNT_W−1.
- States:
  - IDLE: counters, `match_cnt`, `locked` and `err` are 0. Go to WAIT_EDGE when `en` = 1.
  - WAIT_EDGE: ignore the level and wait for the first `rise`. On `rise`, reload the counters and go to MEAS. No `meas_valid` is produced.
  - MEAS, on `rise`:
    - `period` ← `per_cnt`; `high_time` ← `hi_cnt`; pulse `meas_valid`.
    - If `per_cnt` == `EXP_DIV`, `match_cnt` increments (saturating at `LOCK_CNT`) and `locked` = (`match_cnt` + 1 ≥ `LOCK_CNT`).
    - Otherwise `match_cnt` ← 0, `locked` ← 0 and `err` ← 1.
  - MEAS timeout: `per_cnt` reaching 2^CNT_W−1 without a `rise` sets `err`, clears `locked` and `match_cnt`, and returns the FSM to WAIT_EDGE. `period` and `high_time` hold their values.
- `en` low in any state: IDLE on the next edge. `period` and `high_time` clear to 0, and any pending `meas_valid` is suppressed.
- Simultaneous events:
  - `rise` and timeout in the same cycle: `rise` wins and a normal capture occurs.
  - `en` low and `rise` in the same cycle: `en` wins and there is no capture.
- `err` is independent of `locked`: after a mismatch followed by `LOCK_CNT` good periods, `locked` = 1 and `err` remains 1.

## Timing
- Reset values: `period` = 0, `high_time` = 0, `meas_valid` = 0, `locked` = 0, `err` = 0, state = IDLE. All synchronizer and counter flops = 0.
- Latency:
  - A `div_in` rising edge set up before `clk` edge e0 gives `rise` in the cycle after e1.
  - Outputs update at e2 and `meas_valid` is high for exactly one cycle after e2.
- Latency is constant, so measured periods are exact for a `div_in` synchronous to `clk`.
- High time of a negedge-derived 50%-duty odd divider reads ⌊N/2⌋ or ⌈N/2⌉ and is not checked.
- `locked` and `err` change only on the cycle `meas_valid` pulses, except:
  - the timeout update, which occurs in the cycle `per_cnt` saturates;
  - `en` low, which clears them on the next edge.
- `rst` asserted mid-period: all outputs return to reset values immediately (asynchronously). The first capture after release requires two rises.

## Structure
- Shared package `odd_div_pkg` holds:
  - the 2-bit state encoding IDLE = 0, WAIT_EDGE = 1, MEAS = 2;
  - the default `CNT_W` constant, also shared with the divider.
- Sub-module `edge_sync`: contains the 2-flop synchronizer, the `prev` flop and the `rise` output, with asynchronous active-high reset. The top level holds the FSM, the counters and the lock logic.

## Test plan
- Reset, then `en` = 1 with `div_in` a synchronous pattern of 3 high / 2 low cycles → `meas_valid` pulses every 5 cycles; `period` = 5, `high_time` = 3; the first capture occurs on the second rise; `locked` rises on the 4th capture; `err` = 0.
- After lock, insert one period of 7 (4 high / 3 low) → that capture gives `period` = 7, `locked` = 0, `err` = 1. Four further 5-cycle periods → `locked` = 1 again and `err` stays 1.
- Hold `div_in` low after lock with `CNT_W` = 4 → `per_cnt` reaches 15, then `err` = 1, `locked` = 0, the FSM is in WAIT_EDGE, and `period` still reads 5.
- Drop `en` for one cycle while locked → next edge `locked` = 0, `err` = 0, `period` = 0; re-enable → relock after 1 + `LOCK_CNT` rises.
- Assert `rst` asynchronously mid-period → outputs go to 0 before the next `clk` edge; normal capture resumes after release.
- Rise coincident with `en` falling → no `meas_valid` and the FSM is in IDLE.
